// File: rtl/segre_mem_agu_pipe.sv
// Memory-path AGU: effective address, alignment check, byte enables, DEPTH elastic slots.
// Latency: DEPTH-1 edges from accept to output slot; one op per cycle when unstalled.
// Backpressure: out_ready_i low holds the pipe; in_ready_o drops only when every slot is valid.
module segre_mem_agu_pipe #(
    parameter int WORD_W  = 32,
    parameter int REG_W   = 5,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 1,
    parameter int NUM_BYP = 2,
    parameter int SEL_W   = $clog2(NUM_BYP + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        kill_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [WORD_W-1:0]           src_a_i,
    input  logic [WORD_W-1:0]           src_b_i,
    input  logic [WORD_W-1:0]           st_data_i,
    input  logic [SEL_W-1:0]            byp_sel_i,
    input  logic                        rf_we_i,
    input  logic [REG_W-1:0]            rf_waddr_i,
    input  logic                        memop_rd_i,
    input  logic                        memop_wr_i,
    input  logic                        memop_sign_ext_i,
    input  logic [1:0]                  memop_type_i,
    input  logic [ID_W-1:0]             instr_id_i,
    input  logic [NUM_BYP*WORD_W-1:0]   byp_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WORD_W-1:0]           addr_o,
    output logic [WORD_W-1:0]           st_data_o,
    output logic [3:0]                  be_o,
    output logic                        rf_we_o,
    output logic [REG_W-1:0]            rf_waddr_o,
    output logic                        memop_rd_o,
    output logic                        memop_wr_o,
    output logic                        memop_sign_ext_o,
    output logic [1:0]                  memop_type_o,
    output logic [ID_W-1:0]             instr_id_o,
    output logic                        misalign_o,
    output logic [DEPTH-1:0]            slot_we_o,
    output logic [DEPTH*REG_W-1:0]      slot_waddr_o,
    output logic [$clog2(DEPTH+1)-1:0]  occ_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] st_data;
        logic [SEL_W-1:0]  sel;
        logic              rf_we;
        logic [REG_W-1:0]  waddr;
        logic              rd;
        logic              wr;
        logic              sext;
        logic [1:0]        mtype;
        logic [ID_W-1:0]   id;
        logic              misalign;
        logic [3:0]        be;
    } pkt_t;

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] adv, load;
    pkt_t             pkt_q [DEPTH];
    pkt_t             pkt_d [DEPTH];
    pkt_t             ent;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Build the entry packet: address add, type normalisation, alignment and byte enables.
    always_comb begin
        ent          = '0;
        ent.addr     = src_a_i + src_b_i;
        ent.st_data  = st_data_i;
        ent.sel      = byp_sel_i;
        ent.rf_we    = rf_we_i;
        ent.waddr    = rf_waddr_i;
        ent.rd       = memop_rd_i;
        ent.wr       = memop_wr_i;
        ent.sext     = memop_sign_ext_i;
        ent.id       = instr_id_i;
        // Encoding 3 is illegal and behaves exactly like WORD downstream.
        ent.mtype    = (memop_type_i == 2'd3) ? 2'd2 : memop_type_i;
        case (ent.mtype)
            2'd0: begin
                ent.misalign = 1'b0;
                ent.be       = 4'b0001 << ent.addr[1:0];
            end
            2'd1: begin
                ent.misalign = ent.addr[0];
                ent.be       = 4'b0011 << ent.addr[1:0];
            end
            default: begin
                ent.misalign = |ent.addr[1:0];
                ent.be       = 4'hF;
            end
        endcase
        // Misaligned ops keep flowing for exception tracking but must not touch memory or the RF.
        if (ent.misalign) begin
            ent.be    = 4'h0;
            ent.rd    = 1'b0;
            ent.wr    = 1'b0;
            ent.rf_we = 1'b0;
        end
    end

    // Advance chain from the output slot back to the entry; a slot loads when empty or moving.
    always_comb begin
        logic chain;
        chain = out_ready_i;
        adv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = chain;
            chain  = !v_q[k] || chain;
        end
        load = ~v_q | adv;
    end

    // Next-state of slots: shift on load, kill clears every valid bit and drops the entry transfer.
    always_comb begin
        v_d   = v_q;
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) pkt_d[k] = pkt_q[k];
        if (load[0]) begin
            v_d[0]   = in_valid_i;
            pkt_d[0] = ent;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (load[k]) begin
                v_d[k]   = v_q[k-1];
                pkt_d[k] = pkt_q[k-1];
            end
        end
        if (kill_i) v_d = '0;
        for (int k = 0; k < DEPTH; k++) occ_d = occ_d + OCC_W'(v_d[k]);
    end

    // Slot state; reset leaves packets zeroed with type WORD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pkt_q[k]       <= '0;
                pkt_q[k].mtype <= 2'd2;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) pkt_q[k] <= pkt_d[k];
        end
    end

    // Output slot: late bypass select, store-data replication, and valid qualification.
    always_comb begin
        pkt_t              o;
        logic              ov;
        logic [WORD_W-1:0] raw;
        o   = pkt_q[DEPTH-1];
        ov  = v_q[DEPTH-1];
        raw = o.st_data;
        for (int j = 0; j < NUM_BYP; j++) begin
            if (o.sel == SEL_W'(j + 1)) raw = byp_data_i[j*WORD_W +: WORD_W];
        end
        case (o.mtype)
            2'd0:    st_data_o = {4{raw[7:0]}};
            2'd1:    st_data_o = {2{raw[15:0]}};
            default: st_data_o = raw;
        endcase
        if (!ov) st_data_o = '0;
        out_valid_o      = ov;
        addr_o           = ov ? o.addr  : '0;
        be_o             = ov ? o.be    : 4'h0;
        rf_we_o          = ov & o.rf_we;
        rf_waddr_o       = ov ? o.waddr : '0;
        memop_rd_o       = ov & o.rd;
        memop_wr_o       = ov & o.wr;
        memop_sign_ext_o = ov & o.sext;
        memop_type_o     = ov ? o.mtype : 2'd0;
        instr_id_o       = ov ? o.id    : '0;
        misalign_o       = ov & o.misalign;
        in_ready_o       = load[0] & ~rst_i;
        occ_o            = occ_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot_we_o[k]                 = v_q[k] & pkt_q[k].rf_we;
            slot_waddr_o[k*REG_W +: REG_W] = v_q[k] ? pkt_q[k].waddr : '0;
        end
    end

endmodule

// File: tb/tb_segre_mem_agu_pipe.sv
module tb_segre_mem_agu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] src_a = '0, src_b = '0, st_data = '0;
    logic [1:0]  byp_sel = '0;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic        m_rd = 1'b0, m_wr = 1'b0, m_sext = 1'b0;
    logic [1:0]  m_type = 2'd2;
    logic [3:0]  iid = '0;
    logic [63:0] byp_data = '0;
    logic        out_ready = 1'b0;

    // DEPTH=2 instance outputs
    logic        a_in_rdy, a_ov, a_we, a_rd, a_wr, a_sx, a_mis;
    logic [31:0] a_addr, a_st;
    logic [3:0]  a_be, a_id;
    logic [4:0]  a_wa;
    logic [1:0]  a_ty, a_swe, a_occ;
    logic [9:0]  a_swa;
    // DEPTH=3 instance outputs
    logic        b_in_rdy, b_ov, b_we, b_rd, b_wr, b_sx, b_mis;
    logic [31:0] b_addr, b_st;
    logic [3:0]  b_be, b_id;
    logic [4:0]  b_wa;
    logic [1:0]  b_ty, b_occ;
    logic [2:0]  b_swe;
    logic [14:0] b_swa;

    int total = 0;
    int bad   = 0;

    segre_mem_agu_pipe #(.DEPTH(2)) u2 (
        .clk_i(clk), .rst_i(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(a_in_rdy),
        .src_a_i(src_a), .src_b_i(src_b), .st_data_i(st_data), .byp_sel_i(byp_sel),
        .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .memop_rd_i(m_rd), .memop_wr_i(m_wr),
        .memop_sign_ext_i(m_sext), .memop_type_i(m_type), .instr_id_i(iid), .byp_data_i(byp_data),
        .out_valid_o(a_ov), .out_ready_i(out_ready), .addr_o(a_addr), .st_data_o(a_st), .be_o(a_be),
        .rf_we_o(a_we), .rf_waddr_o(a_wa), .memop_rd_o(a_rd), .memop_wr_o(a_wr),
        .memop_sign_ext_o(a_sx), .memop_type_o(a_ty), .instr_id_o(a_id), .misalign_o(a_mis),
        .slot_we_o(a_swe), .slot_waddr_o(a_swa), .occ_o(a_occ)
    );

    segre_mem_agu_pipe #(.DEPTH(3)) u3 (
        .clk_i(clk), .rst_i(rst), .kill_i(kill), .in_valid_i(in_valid), .in_ready_o(b_in_rdy),
        .src_a_i(src_a), .src_b_i(src_b), .st_data_i(st_data), .byp_sel_i(byp_sel),
        .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .memop_rd_i(m_rd), .memop_wr_i(m_wr),
        .memop_sign_ext_i(m_sext), .memop_type_i(m_type), .instr_id_i(iid), .byp_data_i(byp_data),
        .out_valid_o(b_ov), .out_ready_i(out_ready), .addr_o(b_addr), .st_data_o(b_st), .be_o(b_be),
        .rf_we_o(b_we), .rf_waddr_o(b_wa), .memop_rd_o(b_rd), .memop_wr_o(b_wr),
        .memop_sign_ext_o(b_sx), .memop_type_o(b_ty), .instr_id_o(b_id), .misalign_o(b_mis),
        .slot_we_o(b_swe), .slot_waddr_o(b_swa), .occ_o(b_occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ty,
                      input logic rd, input logic wr, input logic we, input logic [4:0] wa,
                      input logic [3:0] id, input logic [31:0] sd, input logic [1:0] sel);
        in_valid = 1'b1; src_a = a; src_b = b; m_type = ty; m_rd = rd; m_wr = wr;
        rf_we = we; rf_waddr = wa; iid = id; st_data = sd; byp_sel = sel;
    endtask

    task automatic flush;
        in_valid = 1'b0; kill = 1'b1;
        tick;
        kill = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ov2",   a_ov, 0);
        chk("rst_occ2",  a_occ, 0);
        chk("rst_ird2",  a_in_rdy, 0);
        chk("rst_type3", b_ty, 0);
        chk("rst_swe3",  b_swe, 0);
        tick;
        rst = 1'b0; out_ready = 1'b1;

        // DEPTH=2: LW, SB, misaligned SH back to back
        op(32'h100, 32'h8, 2'd2, 1, 0, 1, 5'd5, 4'd1, 32'h0, 2'd0);
        tick;
        op(32'h100, 32'h3, 2'd0, 0, 1, 0, 5'd0, 4'd2, 32'hAABBCCDD, 2'd0);
        tick;
        chk("lw_ov",   a_ov, 1);
        chk("lw_addr", a_addr, 32'h108);
        chk("lw_be",   a_be, 4'hF);
        chk("lw_rd",   a_rd, 1);
        chk("lw_wa",   a_wa, 5);
        op(32'h100, 32'h1, 2'd1, 0, 1, 1, 5'd3, 4'd3, 32'h0, 2'd0);
        tick;
        in_valid = 1'b0;
        chk("sb_addr", a_addr, 32'h103);
        chk("sb_st",   a_st, 32'hDDDDDDDD);
        chk("sb_be",   a_be, 4'b1000);
        chk("sb_wr",   a_wr, 1);
        tick;
        chk("sh_mis",  a_mis, 1);
        chk("sh_wr",   a_wr, 0);
        chk("sh_we",   a_we, 0);
        chk("sh_be",   a_be, 0);
        chk("sh_id",   a_id, 3);
        tick;
        chk("drain_ov2", a_ov, 0);
        chk("drain_be2", a_be, 0);
        flush;
        chk("flush_occ3", b_occ, 0);

        // DEPTH=3 backpressure: 4 issue attempts, 3 accepted
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op(32'h200 + 32'(4 * i), 32'h0, 2'd2, 1, 0, 0, 5'd0, 4'(10 + i), 32'h0, 2'd0);
            #1;
            chk("bp_ird", b_in_rdy, (i < 3) ? 1 : 0);
            tick;
        end
        in_valid = 1'b0;
        chk("bp_occ",  b_occ, 3);
        chk("bp_ird_full", b_in_rdy, 0);
        chk("bp_id0",  b_id, 10);
        chk("bp_addr0", b_addr, 32'h200);
        out_ready = 1'b1;
        #1;
        chk("full_drain_ird", b_in_rdy, 1);
        tick;
        chk("bp_id1",  b_id, 11);
        chk("bp_ov1",  b_ov, 1);
        tick;
        chk("bp_id2",  b_id, 12);
        chk("bp_addr2", b_addr, 32'h208);
        tick;
        chk("bp_empty_ov", b_ov, 0);
        chk("bp_empty_occ", b_occ, 0);

        // Late bypass on a SW held in the output slot
        out_ready = 1'b0;
        byp_data = {32'h11111111, 32'h22222222};
        op(32'h300, 32'h0, 2'd2, 0, 1, 0, 5'd0, 4'd4, 32'hDEADBEEF, 2'd2);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("byp_ov",  b_ov, 1);
        chk("byp_st0", b_st, 32'h11111111);
        byp_data[63:32] = 32'h12345678;
        #1;
        chk("byp_st1", b_st, 32'h12345678);
        byp_sel = 2'd0;
        #1;
        chk("byp_carried_sel", b_st, 32'h12345678);
        flush;

        // Hazard outputs then kill with a simultaneous issue
        for (int i = 0; i < 3; i++) begin
            op(32'h400, 32'h0, 2'd2, 1, 0, 1, 5'(7 + i), 4'(i + 1), 32'h0, 2'd0);
            tick;
        end
        chk("hz_occ", b_occ, 3);
        chk("hz_swe", b_swe, 3'b111);
        chk("hz_swa", b_swa, {5'd7, 5'd8, 5'd9});
        op(32'h500, 32'h0, 2'd2, 1, 0, 1, 5'd10, 4'd5, 32'h0, 2'd0);
        kill = 1'b1;
        tick;
        kill = 1'b0; in_valid = 1'b0;
        chk("kill_occ", b_occ, 0);
        chk("kill_ov",  b_ov, 0);
        chk("kill_swe", b_swe, 0);
        tick;
        chk("kill_drop", b_occ, 0);

        // Asynchronous reset mid-cycle with a full pipe
        for (int i = 0; i < 3; i++) begin
            op(32'h600, 32'h4, 2'd2, 1, 0, 1, 5'd2, 4'd6, 32'h0, 2'd0);
            tick;
        end
        in_valid = 1'b0;
        chk("pre_rst_ov", b_ov, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov",   b_ov, 0);
        chk("arst_addr", b_addr, 0);
        chk("arst_occ",  b_occ, 0);
        chk("arst_ird",  b_in_rdy, 0);
        chk("arst_we",   b_we, 0);
        chk("arst_type", b_ty, 0);
        tick;
        rst = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
